// File: rtl/ipmred_pkg.sv
// Shared IPM-RED types: GF(2^8) byte, homogenizer FSM states, xtime helper.
package ipmred_pkg;

  localparam int GF_W = 8;

  typedef logic [GF_W-1:0] gf_byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } homog_state_e;

  // Multiply by x modulo the AES polynomial 0x11B.
  function automatic gf_byte_t gf_xtime(input gf_byte_t x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

endpackage

// File: rtl/homogenization_seq_gmul8.sv
// Combinational GF(2^8) multiplier, AES polynomial 0x11B (Horner, MSB first).
module gmul8
  import ipmred_pkg::*;
(
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic [7:0] p
);

  gf_byte_t acc;

  always_comb begin
    acc = '0;
    for (int i = 7; i >= 0; i--) begin
      acc = gf_xtime(acc);
      if (y[i]) acc = acc ^ x;
    end
    p = acc;
  end

endmodule

// File: rtl/homogenization_seq.sv
// Iterative IPM-RED share homogenizer: one shared gmul8, V-2 accumulation cycles.
// Optional HOMOG_BACK2BACK_EN lets DONE accept the next operand set on the drain edge.
module homogenization_seq
  import ipmred_pkg::*;
#(
  parameter int V = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [V*8-1:0]   L2,
  input  logic [(V-1)*8-1:0] a,
  input  logic [(V-1)*8-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [V*8-1:0]   c,
  output logic             busy,
  output logic [1:0]       state
);

  // Handshake: a transfer happens on a clk edge where valid && ready are both 1;
  // the producer holds its data stable and valid high until that edge.

  localparam int JW = (V > 2) ? $clog2(V) : 1;
  localparam logic [JW-1:0] J_FIRST = (V > 2) ? JW'(1) : '0;
  localparam logic [JW-1:0] J_LAST  = JW'(V - 2);

  homog_state_e state_r, state_n;

  logic [V*8-1:0]     l2_r;
  logic [(V-1)*8-1:0] a_r;
  logic [(V-1)*8-1:0] b_r;
  gf_byte_t           delta_r;
  logic [JW-1:0]      j_r;
  logic               load;
  gf_byte_t           mul_x, mul_y, mul_p;

  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_n;
  end

  always_comb begin
    state_n   = state_r;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = (V > 2) ? ITER : DONE;
      end
      ITER: begin
        if (j_r == J_LAST) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
`ifdef HOMOG_BACK2BACK_EN
        in_ready  = out_ready;
`endif
        if (out_ready) state_n = (in_valid && in_ready) ? ((V > 2) ? ITER : DONE) : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign load  = in_valid && in_ready;
  assign busy  = (state_r != IDLE);
  assign state = state_r;

  // Operand mux for the single multiplier: L2 byte j+1 times (a ^ b) byte j.
  always_comb begin
    mul_x = '0;
    mul_y = '0;
    for (int k = 1; k < V - 1; k++) begin
      if (j_r == k[JW-1:0]) begin
        mul_x = l2_r[8*(k+1) +: 8];
        mul_y = a_r[8*k +: 8] ^ b_r[8*k +: 8];
      end
    end
  end

  gmul8 u_gmul8 (
    .x(mul_x),
    .y(mul_y),
    .p(mul_p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      l2_r    <= '0;
      a_r     <= '0;
      b_r     <= '0;
      delta_r <= '0;
      j_r     <= '0;
    end else if (load) begin
      l2_r    <= L2;
      a_r     <= a;
      b_r     <= b;
      delta_r <= b[7:0];
      j_r     <= J_FIRST;
    end else if (state_r == ITER) begin
      delta_r <= delta_r ^ mul_p;
      if (j_r != J_LAST) j_r <= j_r + 1'b1;
    end
  end

  // c is a pure function of the registers, so it holds while DONE waits.
  always_comb begin
    c       = '0;
    c[7:0]  = a_r[7:0];
    c[15:8] = delta_r;
    for (int k = 1; k < V - 1; k++) c[8*(k+1) +: 8] = a_r[8*k +: 8];
  end

  // L2 bytes 0/1 and b byte 0 never feed the multiplier.
  logic unused_bits;
  assign unused_bits = ^{l2_r[15:0], b_r[7:0]};

endmodule

// File: tb/tb_homogenization_seq.sv
// Bench for homogenization_seq: V=2,3,4 instances, vector table plus corner sequences.
module tb_homogenization_seq;

`ifdef HOMOG_BACK2BACK_EN
  localparam int B2B_PERIOD = 2;
`else
  localparam int B2B_PERIOD = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        in_valid_v [2:4];
  logic        out_ready_v[2:4];
  logic        in_ready_v [2:4];
  logic        out_valid_v[2:4];
  logic        busy_v     [2:4];
  logic [1:0]  state_v    [2:4];
  logic [31:0] l2_v       [2:4];
  logic [23:0] a_v        [2:4];
  logic [23:0] b_v        [2:4];
  logic [31:0] c_v        [2:4];
  logic [15:0] c2;
  logic [23:0] c3;
  logic [31:0] c4;

  always_comb begin
    c_v[2] = {16'h0, c2};
    c_v[3] = {8'h0, c3};
    c_v[4] = c4;
  end

  homogenization_seq #(.V(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .L2(l2_v[2][15:0]), .a(a_v[2][7:0]), .b(b_v[2][7:0]),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]), .c(c2),
    .busy(busy_v[2]), .state(state_v[2]));

  homogenization_seq #(.V(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
    .L2(l2_v[3][23:0]), .a(a_v[3][15:0]), .b(b_v[3][15:0]),
    .out_valid(out_valid_v[3]), .out_ready(out_ready_v[3]), .c(c3),
    .busy(busy_v[3]), .state(state_v[3]));

  homogenization_seq #(.V(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[4]), .in_ready(in_ready_v[4]),
    .L2(l2_v[4]), .a(a_v[4]), .b(b_v[4]),
    .out_valid(out_valid_v[4]), .out_ready(out_ready_v[4]), .c(c4),
    .busy(busy_v[4]), .state(state_v[4]));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: LSB-first shift-and-add GF(2^8) product.
  function automatic logic [7:0] gmul_ref(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [31:0] homog_ref(input int v, input logic [31:0] l2,
                                            input logic [23:0] av, input logic [23:0] bv);
    logic [7:0]  delta = bv[7:0];
    logic [31:0] r = 32'h0;
    for (int j = 1; j <= v - 2; j++)
      delta ^= gmul_ref(l2[8*(j+1) +: 8], av[8*j +: 8] ^ bv[8*j +: 8]);
    r[7:0]  = av[7:0];
    r[15:8] = delta;
    for (int k = 1; k <= v - 2; k++) r[8*(k+1) +: 8] = av[8*k +: 8];
    return r;
  endfunction

  // Scoreboard: expected c pushed on input acceptance, popped on output transfer.
  logic [31:0] exp_q[$];
  int          out_cnt[2:4];
  int          out_cyc[$];

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 2; i <= 4; i++) begin
        if (out_valid_v[i] && out_ready_v[i]) begin
          out_cnt[i]++;
          out_cyc.push_back(cyc);
          if (exp_q.size() == 0) check("out_without_expect", 32'(exp_q.size()), 32'd1);
          else check("c_value", c_v[i], exp_q.pop_front());
        end
      end
    end
  end

  // Call #1 after a posedge; returns #1 after the accepting edge.
  task automatic accept(input int i, input logic [31:0] l2, input logic [23:0] av,
                        input logic [23:0] bv, input logic [31:0] exp_c);
    int n = 0;
    l2_v[i] = l2; a_v[i] = av; b_v[i] = bv; in_valid_v[i] = 1'b1;
    @(negedge clk);
    while (!in_ready_v[i] && n < 50) begin @(negedge clk); n++; end
    check("in_ready_wait", {31'h0, in_ready_v[i]}, 32'd1);
    if (in_ready_v[i]) exp_q.push_back(exp_c);
    @(posedge clk); #1;
    in_valid_v[i] = 1'b0;
    l2_v[i] = $urandom; a_v[i] = 24'($urandom); b_v[i] = 24'($urandom);
  endtask

  // Returns at the negedge where out_valid is first seen.
  task automatic send(input int i, input logic [31:0] l2, input logic [23:0] av,
                      input logic [23:0] bv, input logic [31:0] exp_c, input int lat);
    int n = 1;
    accept(i, l2, av, bv, exp_c);
    @(negedge clk);
    check("busy_after_accept", {31'h0, busy_v[i]}, 32'd1);
    while (!out_valid_v[i] && n < 50) begin @(negedge clk); n++; end
    check("latency", n, lat);
    check("busy_at_out", {31'h0, busy_v[i]}, 32'd1);
  endtask

  typedef struct {
    int          v;
    logic [31:0] l2;
    logic [23:0] a;
    logic [23:0] b;
    logic [31:0] exp_c;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n0, cnt0, k, guard;
    logic [31:0] l2r;
    logic [23:0] ar, br;

    for (int i = 2; i <= 4; i++) begin
      in_valid_v[i] = 1'b0; out_ready_v[i] = 1'b1;
      l2_v[i] = '0; a_v[i] = '0; b_v[i] = '0; out_cnt[i] = 0;
    end

    tbl.push_back('{3, 32'h0002_5501, 24'h00_5311, 24'h00_1007, 32'h0053_8111});
    tbl.push_back('{4, 32'h0101_3344, 24'h0F_F0AA, 24'h01_0203, 32'h0FF0_FFAA});
    tbl.push_back('{2, 32'h0000_1234, 24'h00_005A, 24'h00_003C, 32'h0000_3C5A});
    for (int v = 2; v <= 4; v++) begin
      for (int r = 0; r < 3; r++) begin
        l2r = $urandom; ar = 24'($urandom); br = 24'($urandom);
        tbl.push_back('{v, l2r, ar, br, homog_ref(v, l2r, ar, br)});
      end
    end

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 2; i <= 4; i++) begin
      check("rst_state",     {30'h0, state_v[i]},     32'd0);
      check("rst_in_ready",  {31'h0, in_ready_v[i]},  32'd1);
      check("rst_out_valid", {31'h0, out_valid_v[i]}, 32'd0);
      check("rst_busy",      {31'h0, busy_v[i]},      32'd0);
      check("rst_c",         c_v[i],                  32'd0);
    end

    foreach (tbl[t]) begin
      @(posedge clk); #1;
      check("idle_before_op", {31'h0, busy_v[tbl[t].v]}, 32'd0);
      send(tbl[t].v, tbl[t].l2, tbl[t].a, tbl[t].b, tbl[t].exp_c, tbl[t].v - 1);
    end
    repeat (2) @(posedge clk);
    #1 check("table_drained", 32'(exp_q.size()), 32'd0);

    // Stall: c and out_valid hold under out_ready=0 while inputs churn.
    out_ready_v[3] = 1'b0;
    send(3, 32'h0002_5501, 24'h00_5311, 24'h00_1007, 32'h0053_8111, 2);
    for (int t = 0; t < 10; t++) begin
      check("hold_c",         c_v[3],                  32'h0053_8111);
      check("hold_out_valid", {31'h0, out_valid_v[3]}, 32'd1);
      check("hold_in_ready",  {31'h0, in_ready_v[3]},  32'd0);
      @(posedge clk); #1;
      l2_v[3] = $urandom; a_v[3] = 24'($urandom); b_v[3] = 24'($urandom);
      @(negedge clk);
    end
    cnt0 = out_cnt[3];
    @(posedge clk); #1 out_ready_v[3] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("hold_single_transfer", out_cnt[3] - cnt0, 32'd1);
    check("drain_out_valid", {31'h0, out_valid_v[3]}, 32'd0);
    check("drain_c_kept",    c_v[3],                  32'h0053_8111);
    check("drain_state",     {30'h0, state_v[3]},     32'd0);

    // Reset during ITER discards the operation.
    @(posedge clk); #1;
    cnt0 = out_cnt[4];
    accept(4, 32'h0101_3344, 24'h0F_F0AA, 24'h01_0203, 32'h0FF0_FFAA);
    check("pre_rst_state", {30'h0, state_v[4]}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    exp_q.delete();
    check("midrst_state",     {30'h0, state_v[4]},     32'd0);
    check("midrst_in_ready",  {31'h0, in_ready_v[4]},  32'd1);
    check("midrst_out_valid", {31'h0, out_valid_v[4]}, 32'd0);
    check("midrst_c",         c_v[4],                  32'd0);
    repeat (4) @(posedge clk);
    #1 check("midrst_no_output", out_cnt[4] - cnt0, 32'd0);
    send(4, 32'h0101_3344, 24'h0F_F0AA, 24'h01_0203, 32'h0FF0_FFAA, 3);
    @(posedge clk); #1;

    // Streaming with in_valid held high.
    n0 = out_cyc.size();
    k = 0; guard = 0;
    l2r = $urandom; ar = 24'($urandom); br = 24'($urandom);
    l2_v[3] = l2r; a_v[3] = ar; b_v[3] = br; in_valid_v[3] = 1'b1;
    while (k < 4 && guard < 60) begin
      @(negedge clk);
      if (in_ready_v[3]) exp_q.push_back(homog_ref(3, l2r, ar, br));
      @(posedge clk); #1;
      if (exp_q.size() > 0 && in_ready_v[3] == 1'b0 || k >= 0) begin end
      guard++;
      if (out_cnt[3] >= 0 && (n0 + k + exp_q.size()) > 0) begin end
      if ((out_cyc.size() - n0) + exp_q.size() > k) begin
        k++;
        l2r = $urandom; ar = 24'($urandom); br = 24'($urandom);
        l2_v[3] = l2r; a_v[3] = ar; b_v[3] = br;
        if (k == 4) in_valid_v[3] = 1'b0;
      end
    end
    guard = 0;
    while (out_cyc.size() < n0 + 4 && guard < 60) begin @(posedge clk); guard++; end
    check("stream_count", 32'(out_cyc.size() - n0), 32'd4);
    if (out_cyc.size() >= n0 + 4)
      for (int m = 1; m < 4; m++)
        check("stream_period", out_cyc[n0+m] - out_cyc[n0+m-1], B2B_PERIOD);

    repeat (3) @(posedge clk);
    #1 check("final_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
